// File: rtl/cmd_pkg.sv
// Shared types and widths for the UART command wrapper.
package cmd_pkg;

  localparam int unsigned CMD_W = 16;

  typedef enum logic [1:0] {
    WAIT_HI,
    WAIT_LO,
    CMD_HOLD
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte timeout counter: counts enabled cycles, pulses expired on the last one and wraps to 0.
module cmd_timeout_cnt #(
  parameter int unsigned       TO_W      = 20,
  parameter logic [TO_W-1:0]   TO_CYCLES = 20'hF_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LastCnt = TO_CYCLES - 1'b1;

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Assembles two UART bytes into a 16-bit command (high byte first) and forwards
// 8-bit responses to the UART transmitter, with an inter-byte timeout on reception.
module cmd_uart_wrapper
  import cmd_pkg::*;
#(
  parameter int unsigned     TO_W      = 20,
  parameter logic [TO_W-1:0] TO_CYCLES = 20'hF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rx_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic [7:0]       resp,
  input  logic             send_resp,
  output logic             tx_trmt,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             resp_sent,
  output logic             frame_err
);

  rx_state_t        rx_state_q, rx_state_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_trmt_q, tx_trmt_d;
  logic             resp_sent_q, resp_sent_d;
  logic             to_clr, to_en, to_expired;

  cmd_timeout_cnt #(
    .TO_W      (TO_W),
    .TO_CYCLES (TO_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    cmd_d      = cmd_q;
    clr_rx_rdy = 1'b0;
    frame_err  = 1'b0;
    to_clr     = 1'b0;
    to_en      = 1'b0;
    unique case (rx_state_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          cmd_d[15:8] = rx_data;
          clr_rx_rdy  = 1'b1;
          to_clr      = 1'b1;
          rx_state_d  = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the expiry cycle still completes the command.
        if (rx_rdy) begin
          cmd_d[7:0] = rx_data;
          clr_rx_rdy = 1'b1;
          rx_state_d = CMD_HOLD;
        end else begin
          to_en = 1'b1;
          if (to_expired) begin
            frame_err  = 1'b1;
            rx_state_d = WAIT_HI;
          end
        end
      end
      CMD_HOLD: begin
        // Pending bytes stay in the receiver until the consumer releases cmd.
        if (clr_cmd_rdy) begin
          rx_state_d = WAIT_HI;
        end
      end
      default: rx_state_d = WAIT_HI;
    endcase
    if (rst) begin
      clr_rx_rdy = 1'b0;
      frame_err  = 1'b0;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    tx_trmt_d   = 1'b0;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d  = resp;
          tx_trmt_d  = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= WAIT_HI;
      tx_state_q  <= TX_IDLE;
      cmd_q       <= '0;
      tx_data_q   <= '0;
      tx_trmt_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      cmd_q       <= cmd_d;
      tx_data_q   <= tx_data_d;
      tx_trmt_q   <= tx_trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = (rx_state_q == CMD_HOLD);
  assign tx_data   = tx_data_q;
  assign tx_trmt   = tx_trmt_q;
  assign resp_sent = resp_sent_q;

endmodule
